// File: rtl/ctile_store_writer.sv
// ctile_store_writer: streams an M x N result tile into an SRAM write port, one element per
// accepted cycle, in row-major order (column fastest).
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start           begin a store (honoured only when idle); the tile is snapshotted then
//   busy, done      store in progress; one-cycle completion pulse
//   C_tile_flat     tile input, element (r,n) at [(r*N+n)*DATA_W +: DATA_W]
//   c_en, c_we      write strobe pair
//   c_row, c_n      element address
//   c_wdata         element data
//   c_wmask         byte mask (all ones while writing)
//   c_wready        SRAM accepts the presented write this cycle
//   stall_cycles    (only with CTILE_STORE_STALLCNT_EN) saturating count of stalled write cycles
//
// Optional feature macro: CTILE_STORE_STALLCNT_EN
//
// Every output is a flop loaded from next-state values, so c_wready only steers the next
// state and never reaches an output combinationally.
module ctile_store_writer #(
   parameter int M      = 8,
   parameter int N      = 8,
   parameter int DATA_W = 32,
   parameter int BYTE_W = DATA_W / 8,
   parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
   parameter int N_W    = (N <= 1) ? 1 : $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [M*N*DATA_W-1:0] C_tile_flat,
   output logic                  c_en,
   output logic                  c_we,
   output logic [ROW_W-1:0]      c_row,
   output logic [N_W-1:0]        c_n,
   output logic [DATA_W-1:0]     c_wdata,
   output logic [BYTE_W-1:0]     c_wmask,
   input  logic                  c_wready
`ifdef CTILE_STORE_STALLCNT_EN
   ,
   output logic [31:0]           stall_cycles
`endif
);

   typedef enum logic [1:0] {StIdle, StWrite, StFin} state_e;

   state_e                  state_q, state_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [N_W-1:0]          col_q, col_d;
   logic [M*N*DATA_W-1:0]   snap_q, snap_d;
   logic [DATA_W-1:0]       wdata_d;
   logic                    write_d;
`ifdef CTILE_STORE_STALLCNT_EN
   logic [31:0]             stall_d;
`endif

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      snap_d  = snap_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               snap_d  = C_tile_flat;
               row_d   = '0;
               col_d   = '0;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (c_wready) begin
               // Last element: leave the counters parked rather than wrapping.
               if (row_q == ROW_W'(M - 1) && col_q == N_W'(N - 1)) begin
                  state_d = StFin;
               end else if (col_q == N_W'(N - 1)) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Element select for the next presented write, taken from the next snapshot so the
   // very first write after start already carries the captured element.
   always_comb begin
      write_d = (state_d == StWrite);
      wdata_d = '0;
      for (int r = 0; r < M; r++) begin
         for (int n = 0; n < N; n++) begin
            if (row_d == ROW_W'(r) && col_d == N_W'(n)) begin
               wdata_d = snap_d[(r*N+n)*DATA_W +: DATA_W];
            end
         end
      end
   end

`ifdef CTILE_STORE_STALLCNT_EN
   always_comb begin
      stall_d = stall_cycles;
      if (state_q == StIdle && start) begin
         stall_d = '0;
      end else if (state_q == StWrite && !c_wready && stall_cycles != '1) begin
         stall_d = stall_cycles + 32'd1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         row_q   <= '0;
         col_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         c_en    <= 1'b0;
         c_we    <= 1'b0;
         c_row   <= '0;
         c_n     <= '0;
         c_wdata <= '0;
         c_wmask <= '0;
`ifdef CTILE_STORE_STALLCNT_EN
         stall_cycles <= '0;
`endif
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         busy    <= (state_d != StIdle);
         done    <= (state_d == StFin);
         c_en    <= write_d;
         c_we    <= write_d;
         c_row   <= write_d ? row_d : '0;
         c_n     <= write_d ? col_d : '0;
         c_wdata <= write_d ? wdata_d : '0;
         c_wmask <= write_d ? '1 : '0;
`ifdef CTILE_STORE_STALLCNT_EN
         stall_cycles <= stall_d;
`endif
      end
   end

   // Snapshot needs no reset: it is only visible through c_wdata while writing.
   always_ff @(posedge clk) begin
      snap_q <= snap_d;
   end

endmodule

// File: tb/tb_ctile_store_writer.sv
module tb_ctile_store_writer;

   localparam int M  = 8;
   localparam int N  = 8;
   localparam int DW = 32;
   localparam int NE = M * N;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              c_wready = 1'b1;
   logic [NE*DW-1:0]  flat = '0;
   logic              busy, done, c_en, c_we;
   logic [2:0]        c_row, c_n;
   logic [DW-1:0]     c_wdata;
   logic [3:0]        c_wmask;
`ifdef CTILE_STORE_STALLCNT_EN
   logic [31:0]       stall_cycles;
`endif

   // 1x1 instance for the degenerate tile.
   logic              s_start = 1'b0;
   logic [DW-1:0]     s_flat = '0;
   logic              s_busy, s_done, s_en, s_we;
   logic [0:0]        s_row, s_n;
   logic [DW-1:0]     s_wdata;
   logic [3:0]        s_wmask;
`ifdef CTILE_STORE_STALLCNT_EN
   logic [31:0]       s_stall;
`endif

   ctile_store_writer #(.M(M), .N(N), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .C_tile_flat(flat),
      .c_en(c_en), .c_we(c_we), .c_row(c_row), .c_n(c_n), .c_wdata(c_wdata),
      .c_wmask(c_wmask), .c_wready(c_wready)
`ifdef CTILE_STORE_STALLCNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   ctile_store_writer #(.M(1), .N(1), .DATA_W(DW)) dut_small (
      .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
      .C_tile_flat(s_flat), .c_en(s_en), .c_we(s_we), .c_row(s_row), .c_n(s_n),
      .c_wdata(s_wdata), .c_wmask(s_wmask), .c_wready(1'b1)
`ifdef CTILE_STORE_STALLCNT_EN
      , .stall_cycles(s_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the tile as an array, expected writes as a row-major queue.
   typedef struct {
      int          row;
      int          col;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] tile[NE];

   function automatic logic [NE*DW-1:0] pack_tile();
      logic [NE*DW-1:0] f;
      for (int i = 0; i < NE; i++) f[i*DW +: DW] = tile[i];
      return f;
   endfunction

   // c_wready driver: 0 = always ready, 1 = random, 2 = three stalls at element (2,5)
   int wr_mode    = 0;
   int stall_left = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (wr_mode)
            1: c_wready = ($urandom_range(0, 9) < 7);
            2: begin
               if (c_en === 1'b1 && c_row == 3'd2 && c_n == 3'd5 && stall_left > 0) begin
                  c_wready = 1'b0;
                  stall_left--;
               end else begin
                  c_wready = 1'b1;
               end
            end
            default: c_wready = 1'b1;
         endcase
      end
   end

   // Monitor: transaction-level expectation of the port, updated once per cycle.
   bit m_active = 0;
   bit m_fin    = 0;
   int m_stalls = 0;

   initial begin
      forever begin
         @(negedge clk);
         chk("busy", busy, m_active);
         chk("done", done, m_fin);
         chk("c_en", c_en, m_active && !m_fin);
         chk("c_we", c_we, m_active && !m_fin);
         if (m_active && !m_fin) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got row %0d col %0d expected none", c_row, c_n);
            end else begin
               chk("c_row", c_row, exp_q[0].row);
               chk("c_n", c_n, exp_q[0].col);
               chk("c_wdata", c_wdata, exp_q[0].data);
               chk("c_wmask", c_wmask, 4'hF);
            end
         end else begin
            chk("idle_outputs_zero", {c_row, c_n, c_wdata, c_wmask}, 64'd0);
         end
`ifdef CTILE_STORE_STALLCNT_EN
         if (m_fin) chk("stall_cycles", stall_cycles, m_stalls);
`endif
         if (rst) begin
            m_active = 0;
            m_fin    = 0;
            m_stalls = 0;
            exp_q.delete();
         end else if (m_fin) begin
            m_fin    = 0;
            m_active = 0;
         end else if (m_active) begin
            if (c_wready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               if (exp_q.size() == 0) m_fin = 1;
            end else begin
               m_stalls++;
            end
         end else if (start) begin
            m_active = 1;
            m_stalls = 0;
         end
      end
   end

   // Drive a start for the current tile; returns just after the edge that samples it.
   task automatic start_store();
      @(posedge clk);
      #1;
      flat  = pack_tile();
      start = 1'b1;
      for (int i = 0; i < NE; i++) exp_q.push_back('{i / N, i % N, tile[i]});
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (k < 2000) begin
         @(negedge clk);
         k++;
         if (busy === 1'b0) break;
      end
      if (k >= 2000) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, k);
      end
   endtask

   task automatic check_latency(input string name, input int exp_cycles);
      int k;
      k = 0;
      while (k < 400) begin
         @(negedge clk);
         k++;
         if (done === 1'b1) break;
      end
      chk(name, k, exp_cycles);
   endtask

   task automatic random_tile();
      for (int i = 0; i < NE; i++) tile[i] = $urandom;
   endtask

   task automatic ramp_tile();
      for (int i = 0; i < NE; i++) tile[i] = i;
   endtask

   initial begin
      logic [31:0] s_tile;
      int          nw;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Degenerate 1x1 tile: one write, then done, busy for two cycles.
      s_tile = $urandom;
      @(posedge clk);
      #1;
      s_start = 1'b1;
      s_flat  = s_tile;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      s_flat  = ~s_tile;
      @(negedge clk);
      chk("small_busy_w", s_busy, 1'b1);
      chk("small_en_w", s_en, 1'b1);
      chk("small_we_w", s_we, 1'b1);
      chk("small_addr", {s_row, s_n}, 2'b00);
      chk("small_wdata", s_wdata, s_tile);
      chk("small_done_w", s_done, 1'b0);
      @(negedge clk);
      chk("small_busy_f", s_busy, 1'b1);
      chk("small_en_f", s_en, 1'b0);
      chk("small_done_f", s_done, 1'b1);
      @(negedge clk);
      chk("small_busy_i", s_busy, 1'b0);
      chk("small_done_i", s_done, 1'b0);

      // Ramp tile, always ready: 64 writes, done in cycle 65.
      wr_mode = 0;
      ramp_tile();
      start_store();
      check_latency("latency_ready", 65);
      wait_idle();

      // Three stall cycles at (2,5): done three cycles later.
      wr_mode    = 2;
      stall_left = 3;
      start_store();
      check_latency("latency_stall", 68);
      wait_idle();
      wr_mode = 0;

      // Second start mid-store with a different tile is ignored.
      random_tile();
      start_store();
      repeat (9) @(posedge clk);
      #1;
      flat  = ~flat;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      // Tile input overwritten one cycle after start.
      ramp_tile();
      start_store();
      flat = {NE{32'hDEADBEEF}};
      wait_idle();

      // Reset mid-store, then a fresh store from (0,0).
      wr_mode = 1;
      random_tile();
      start_store();
      nw = 0;
      for (int k = 0; k < 1000 && nw < 30; k++) begin
         @(negedge clk);
         if (c_en === 1'b1 && c_wready) nw++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      random_tile();
      start_store();
      wait_idle();

      // start together with rst is ignored.
      @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);

      // Random tiles under random back-pressure.
      for (int t = 0; t < 4; t++) begin
         random_tile();
         start_store();
         wait_idle();
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ctile_store_writer.md
CTILE_STORE_WRITER -- requirements
Module: ctile_store_writer

Interface
REQ-001 The block SHALL provide parameter M, default 8, meaning the number of C tile rows.
REQ-002 The block SHALL provide parameter N, default 8, meaning the number of C tile columns.
REQ-003 The block SHALL provide parameter DATA_W, default 32, meaning the element width in bits.
REQ-004 The block SHALL provide parameter BYTE_W, default DATA_W/8, meaning the number of write-mask bits.
REQ-005 The block SHALL provide parameter ROW_W, default (M<=1)?1:$clog2(M), meaning the row address width.
REQ-006 The block SHALL provide parameter N_W, default (N<=1)?1:$clog2(N), meaning the column address width.
REQ-007 The block SHALL provide port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL provide the command ports start (in, 1), busy (out, 1) and done (out, 1): start a store, store in progress, one-cycle completion pulse.
REQ-010 The block SHALL provide port C_tile_flat, input, M*N*DATA_W bits: the result tile; element (r,n) is at bits [(r*N+n)*DATA_W +: DATA_W].
REQ-011 The block SHALL provide the SRAM write ports c_en (out, 1), c_we (out, 1), c_row (out, ROW_W), c_n (out, N_W), c_wdata (out, DATA_W) and c_wmask (out, BYTE_W).
REQ-012 The block SHALL provide port c_wready, input, 1 bit: the SRAM accepts the presented write in this cycle.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WRITE and FIN.
REQ-014 In IDLE, start=1 SHALL snapshot C_tile_flat into an internal tile register, clear the row and column counters to 0, and enter WRITE on the next edge.
REQ-015 start while in WRITE or FIN SHALL be ignored; the snapshot and counters SHALL be unchanged.
REQ-016 In WRITE: c_en=c_we=1, c_row=row counter, c_n=column counter, c_wdata=snapshot element (row,col), c_wmask all ones.
REQ-017 A write SHALL be accepted in any WRITE cycle with c_wready=1; the counters SHALL then advance row-major, column fastest (col wraps N-1 to 0 and row increments).
REQ-018 In a WRITE cycle with c_wready=0, all c_* outputs and counters SHALL hold their values (stall).
REQ-019 Acceptance at (M-1,N-1) SHALL move the FSM to FIN; the counters SHALL NOT wrap past the last element.
REQ-020 FIN SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in every other cycle.
REQ-021 busy SHALL be 1 in WRITE and FIN, and 0 in IDLE.
REQ-022 Outside WRITE: c_en=c_we=0, and c_row, c_n, c_wdata and c_wmask SHALL be 0.
REQ-023 Latency with c_wready held at 1: start at edge t; the first write is presented after t; done is high in the cycle after edge t+M*N.
REQ-024 Changes to C_tile_flat after the snapshot SHALL NOT affect the stored data.
REQ-025 All outputs SHALL be registered; c_wready SHALL only qualify acceptance and SHALL have no combinational path to any output.

Reset
REQ-026 rst=1 at any edge, including mid-WRITE, SHALL force IDLE with busy, done, c_en and c_we at 0, counters and c_* outputs at 0, and the pending store abandoned.
REQ-027 The snapshot register SHALL need no reset value; it is never observable in IDLE.
REQ-028 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-029 With macro CTILE_STORE_STALLCNT_EN defined, the block SHALL add output stall_cycles (32 bits).
REQ-030 stall_cycles SHALL clear to 0 on rst and on an accepted start, increment in each WRITE cycle with c_wready=0, and saturate at 2^32-1.
REQ-031 Without CTILE_STORE_STALLCNT_EN defined, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 M=N=8, element (r,n)=r*8+n, c_wready=1 -> 64 writes in order (0,0)..(7,7) with wdata 0..63, wmask=4'hF; done high in cycle 65 after start.
REQ-033 c_wready=0 for 3 cycles at element (2,5) -> c_row=2, c_n=5, wdata=21 held for 3 cycles; done 3 cycles later than in REQ-032; stall_cycles=3 with the macro defined.
REQ-034 start pulsed again at write 10 with a different C_tile_flat -> ignored; all 64 written values are from the first snapshot.
REQ-035 C_tile_flat changed to all 32'hDEADBEEF one cycle after start -> written data still 0..63.
REQ-036 rst asserted after write 30 -> next cycle busy=0, c_en=0, done never pulses; a following start writes from (0,0).
REQ-037 M=N=1, c_wready=1 -> exactly one write at (0,0), then done on the following cycle, busy high for 2 cycles.
